// File: rtl/pulp_io_gpio.sv
// rtl/pulp_io_gpio.sv - APB GPIO block with input sync, per-pin glitch filter and edge/level interrupts
module pulp_io_gpio #(
    parameter int NUM_GPIOS      = 32,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int FILT_W         = 4
) (
    input  logic                      sys_clk_i,
    input  logic                      sys_rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] apb_paddr,
    input  logic [31:0]               apb_pwdata,
    input  logic                      apb_pwrite,
    input  logic                      apb_psel,
    input  logic                      apb_penable,
    output logic [31:0]               apb_prdata,
    output logic                      apb_pready,
    output logic                      apb_pslverr,
    input  logic [NUM_GPIOS-1:0]      gpio_in,
    output logic [NUM_GPIOS-1:0]      gpio_out,
    output logic [NUM_GPIOS-1:0]      gpio_tx_en_o,
    output logic [NUM_GPIOS-1:0]      gpio_in_sync_o,
    output logic                      gpio_interrupt_o
);
    localparam int N = NUM_GPIOS;
    // Two mode bits per pin; bits belonging to absent pins are never stored
    localparam logic [63:0] MODE_MASK = (64'd1 << (2 * N)) - 64'd1;

    localparam logic [3:0] OFF_DIR     = 4'd0;
    localparam logic [3:0] OFF_OUT     = 4'd1;
    localparam logic [3:0] OFF_IN      = 4'd2;
    localparam logic [3:0] OFF_SET     = 4'd3;
    localparam logic [3:0] OFF_CLR     = 4'd4;
    localparam logic [3:0] OFF_INTEN   = 4'd5;
    localparam logic [3:0] OFF_MODE_LO = 4'd6;
    localparam logic [3:0] OFF_MODE_HI = 4'd7;
    localparam logic [3:0] OFF_INTSTAT = 4'd8;
    localparam logic [3:0] OFF_FILTEN  = 4'd9;
    localparam logic [3:0] OFF_FILTCNT = 4'd10;

    logic [N-1:0]      r_dir, r_out, r_inten, r_intstat, r_filten;
    logic [63:0]       r_mode;
    logic [FILT_W-1:0] r_filtcnt;
    logic [N-1:0]      r_sync1, r_sync2, r_filt, r_filt_d;
    logic [FILT_W-1:0] r_cnt [N];

    logic              w_access, w_wr, w_rd, w_mapped, w_cfg_wr;
    logic [3:0]        w_off;
    logic [N-1:0]      w_wdata, w_clr, w_event;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_off    = apb_paddr[5:2];
    assign w_access = apb_psel & apb_penable;
    assign w_mapped = (w_off <= OFF_FILTCNT);
    assign w_wr     = w_access & apb_pwrite & w_mapped;
    assign w_rd     = w_access & ~apb_pwrite & w_mapped;
    assign w_wdata  = apb_pwdata[N-1:0];
    assign w_cfg_wr = w_wr & ((w_off == OFF_FILTEN) | (w_off == OFF_FILTCNT));
    assign w_clr    = (w_wr && w_off == OFF_INTSTAT) ? w_wdata : '0;
    assign w_unused = ^{apb_paddr, apb_pwdata};

    assign apb_pready       = 1'b1;
    assign apb_pslverr      = w_access & ~w_mapped;
    assign apb_prdata       = w_rd ? w_rdata : 32'd0;
    assign gpio_out         = r_out;
    assign gpio_tx_en_o     = r_dir;
    assign gpio_in_sync_o   = r_sync2;
    assign gpio_interrupt_o = |(r_intstat & r_inten);

    // Register file writes; SET/CLR modify OUT in the access cycle
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            r_dir     <= '0;
            r_out     <= '0;
            r_inten   <= '0;
            r_mode    <= '0;
            r_filten  <= '0;
            r_filtcnt <= '0;
        end else if (w_wr) begin
            case (w_off)
                OFF_DIR:     r_dir     <= w_wdata;
                OFF_OUT:     r_out     <= w_wdata;
                OFF_SET:     r_out     <= r_out | w_wdata;
                OFF_CLR:     r_out     <= r_out & ~w_wdata;
                OFF_INTEN:   r_inten   <= w_wdata;
                OFF_MODE_LO: r_mode    <= {r_mode[63:32], apb_pwdata} & MODE_MASK;
                OFF_MODE_HI: r_mode    <= {apb_pwdata, r_mode[31:0]} & MODE_MASK;
                OFF_FILTEN:  r_filten  <= w_wdata;
                OFF_FILTCNT: r_filtcnt <= apb_pwdata[FILT_W-1:0];
                default:     ;
            endcase
        end
    end

    // Read mux; WO and unmapped offsets return zero
    always_comb begin
        w_rdata = 32'd0;
        case (w_off)
            OFF_DIR:     w_rdata = 32'(r_dir);
            OFF_OUT:     w_rdata = 32'(r_out);
            OFF_IN:      w_rdata = 32'(r_filt);
            OFF_INTEN:   w_rdata = 32'(r_inten);
            OFF_MODE_LO: w_rdata = r_mode[31:0];
            OFF_MODE_HI: w_rdata = r_mode[63:32];
            OFF_INTSTAT: w_rdata = 32'(r_intstat);
            OFF_FILTEN:  w_rdata = 32'(r_filten);
            OFF_FILTCNT: w_rdata = 32'(r_filtcnt);
            default:     w_rdata = 32'd0;
        endcase
    end

    // Two-flop synchroniser on the raw pads
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
        end
    end

    // Per-pin glitch filter: filt follows sync2 only after FILTCNT+1 stable mismatching cycles
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            r_filt   <= '0;
            r_filt_d <= '0;
            for (int i = 0; i < N; i++) r_cnt[i] <= '0;
        end else begin
            r_filt_d <= r_filt;
            for (int i = 0; i < N; i++) begin
                if (!r_filten[i]) begin
                    r_filt[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else if (r_sync2[i] == r_filt[i]) begin
                    r_cnt[i]  <= '0;
                end else if (r_cnt[i] == r_filtcnt) begin
                    r_filt[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i]  <= r_cnt[i] + 1'b1;
                end
                // A config change restarts every count against the new settings
                if (w_cfg_wr) r_cnt[i] <= '0;
            end
        end
    end

    // Event detection per pin according to its two-bit mode
    always_comb begin
        w_event = '0;
        for (int i = 0; i < N; i++) begin
            case (r_mode[2*i +: 2])
                2'b00:   w_event[i] = r_filt[i] & ~r_filt_d[i];
                2'b01:   w_event[i] = ~r_filt[i] & r_filt_d[i];
                2'b10:   w_event[i] = r_filt[i] ^ r_filt_d[i];
                default: w_event[i] = r_filt[i];
            endcase
        end
    end

    // Interrupt status: write-1-to-clear, a simultaneous enabled event wins
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) r_intstat <= '0;
        else             r_intstat <= (r_intstat & ~w_clr) | (w_event & r_inten);
    end
endmodule

// File: tb/tb_pulp_io_gpio.sv
// tb/tb_pulp_io_gpio.sv - table-driven bench for pulp_io_gpio
module tb_pulp_io_gpio;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [31:0] gin = '0;
    logic [31:0] gout, gtx, gsync;
    logic        irq;

    int n_vec = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pulp_io_gpio dut (
        .sys_clk_i(clk), .sys_rst_ni(rst_n),
        .apb_paddr(paddr), .apb_pwdata(pwdata), .apb_pwrite(pwrite),
        .apb_psel(psel), .apb_penable(penable),
        .apb_prdata(prdata), .apb_pready(pready), .apb_pslverr(pslverr),
        .gpio_in(gin), .gpio_out(gout), .gpio_tx_en_o(gtx),
        .gpio_in_sync_o(gsync), .gpio_interrupt_o(irq)
    );

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] exp_out;
        logic [31:0] exp_dir;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                       output logic [31:0] rd, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(negedge clk);
        penable = 1'b1;
        #1;
        rd = prdata;
        err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr_reg(input logic [11:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic err;
        apb(1'b1, addr, data, rd, err);
    endtask

    task automatic rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic err;
        apb(1'b0, addr, 32'd0, rd, err);
        chk(name, rd, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic err;

        vecs[0]  = '{1'b1, 12'h000, 32'h0000_00FF, 32'h0, 1'b0, 32'h00, 32'hFF};
        vecs[1]  = '{1'b1, 12'h004, 32'h0000_000F, 32'h0, 1'b0, 32'h0F, 32'hFF};
        vecs[2]  = '{1'b1, 12'h00C, 32'h0000_0030, 32'h0, 1'b0, 32'h3F, 32'hFF};
        vecs[3]  = '{1'b1, 12'h010, 32'h0000_0001, 32'h0, 1'b0, 32'h3E, 32'hFF};
        vecs[4]  = '{1'b0, 12'h004, 32'h0, 32'h3E, 1'b0, 32'h3E, 32'hFF};
        vecs[5]  = '{1'b0, 12'h000, 32'h0, 32'hFF, 1'b0, 32'h3E, 32'hFF};
        vecs[6]  = '{1'b0, 12'h00C, 32'h0, 32'h00, 1'b0, 32'h3E, 32'hFF};
        vecs[7]  = '{1'b0, 12'h02C, 32'h0, 32'h00, 1'b1, 32'h3E, 32'hFF};
        vecs[8]  = '{1'b1, 12'h02C, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h3E, 32'hFF};
        vecs[9]  = '{1'b1, 12'h01C, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h3E, 32'hFF};
        vecs[10] = '{1'b0, 12'h01C, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h3E, 32'hFF};
        vecs[11] = '{1'b1, 12'h028, 32'h0000_00FF, 32'h0, 1'b0, 32'h3E, 32'hFF};
        vecs[12] = '{1'b0, 12'h028, 32'h0, 32'h0000_000F, 1'b0, 32'h3E, 32'hFF};
        vecs[13] = '{1'b1, 12'h028, 32'h0, 32'h0, 1'b0, 32'h3E, 32'hFF};
        vecs[14] = '{1'b0, 12'h008, 32'h0, 32'h0, 1'b0, 32'h3E, 32'hFF};
        vecs[15] = '{1'b0, 12'h03C, 32'h0, 32'h0, 1'b1, 32'h3E, 32'hFF};

        // Reset values
        #3;
        chk("rst_out", gout, 32'h0);
        chk("rst_tx_en", gtx, 32'h0);
        chk("rst_sync", gsync, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_pslverr", {31'd0, pslverr}, 32'h0);
        chk("rst_pready", {31'd0, pready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);

        // Register access table
        for (int i = 0; i < 16; i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, err);
            chk($sformatf("v%0d_prdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_pslverr", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_out", i), gout, vecs[i].exp_out);
            chk($sformatf("v%0d_tx_en", i), gtx, vecs[i].exp_dir);
        end
        chk("idle_prdata", prdata, 32'h0);

        // Rising-edge interrupt on pin 3 with k+1/k+3 latency
        wr_reg(12'h014, 32'h0000_0008);
        @(negedge clk);
        gin[3] = 1'b1;
        @(posedge clk); #1;
        chk("rise_k0_irq", {31'd0, irq}, 32'h0);
        @(posedge clk); #1;
        chk("rise_k1_sync", gsync, 32'h8);
        chk("rise_k1_irq", {31'd0, irq}, 32'h0);
        @(posedge clk); #1;
        chk("rise_k2_irq", {31'd0, irq}, 32'h0);
        @(posedge clk); #1;
        chk("rise_k3_irq", {31'd0, irq}, 32'h1);
        rd_chk("rise_status", 12'h020, 32'h8);
        wr_reg(12'h020, 32'h8);
        chk("rise_w1c_irq", {31'd0, irq}, 32'h0);
        rd_chk("rise_w1c_status", 12'h020, 32'h0);

        // Events on a disabled pin are discarded
        @(negedge clk); gin[5] = 1'b1;
        cyc(3);
        @(negedge clk); gin[5] = 1'b0;
        cyc(5);
        rd_chk("mask_status", 12'h020, 32'h0);
        wr_reg(12'h014, 32'h0000_0028);
        chk("mask_irq", {31'd0, irq}, 32'h0);

        // Glitch filter on pin 0, FILTCNT = 3
        wr_reg(12'h024, 32'h1);
        wr_reg(12'h028, 32'h3);
        wr_reg(12'h014, 32'h1);
        @(negedge clk); gin[0] = 1'b1;
        repeat (2) @(negedge clk);
        gin[0] = 1'b0;
        cyc(8);
        rd_chk("filt_short_in", 12'h008, 32'h8);
        chk("filt_short_irq", {31'd0, irq}, 32'h0);
        @(negedge clk); gin[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("filt_long_sync", gsync, 32'h9);
        cyc(4);
        chk("filt_k5_irq", {31'd0, irq}, 32'h0);
        cyc(1);
        chk("filt_k6_irq", {31'd0, irq}, 32'h1);
        rd_chk("filt_long_in", 12'h008, 32'h9);
        repeat (4) @(negedge clk);
        gin[0] = 1'b0;
        cyc(10);
        wr_reg(12'h020, 32'h1);
        rd_chk("filt_clr_status", 12'h020, 32'h0);
        rd_chk("filt_fall_in", 12'h008, 32'h8);

        // Level mode on pin 20
        wr_reg(12'h024, 32'h0);
        wr_reg(12'h01C, 32'h0000_0300);
        wr_reg(12'h014, 32'h0010_0000);
        @(negedge clk); gin[20] = 1'b1;
        cyc(5);
        rd_chk("lvl_status", 12'h020, 32'h0010_0000);
        wr_reg(12'h020, 32'h0010_0000);
        chk("lvl_w1c_irq", {31'd0, irq}, 32'h1);
        rd_chk("lvl_w1c_status", 12'h020, 32'h0010_0000);
        wr_reg(12'h014, 32'h0);
        chk("lvl_masked_irq", {31'd0, irq}, 32'h0);
        rd_chk("lvl_masked_status", 12'h020, 32'h0010_0000);

        // Asynchronous reset mid-operation
        wr_reg(12'h014, 32'h0010_0000);
        wr_reg(12'h004, 32'hFFFF_FFFF);
        chk("pre_rst_out", gout, 32'hFFFF_FFFF);
        chk("pre_rst_irq", {31'd0, irq}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", gout, 32'h0);
        chk("async_rst_tx_en", gtx, 32'h0);
        chk("async_rst_sync", gsync, 32'h0);
        chk("async_rst_irq", {31'd0, irq}, 32'h0);
        chk("async_rst_prdata", prdata, 32'h0);
        chk("async_rst_pslverr", {31'd0, pslverr}, 32'h0);
        chk("async_rst_pready", {31'd0, pready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4);
        chk("post_rst_sync", gsync, 32'h0010_0008);
        chk("post_rst_irq", {31'd0, irq}, 32'h0);
        rd_chk("post_rst_status", 12'h020, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
